// File: rtl/npu_pkg.sv
// npu_pkg: shared state encoding, config word field positions and default widths
package npu_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W = 16;
  localparam int CFG_SEL_IN_BIT = DEF_CNT_W + 1;
  localparam int CFG_SEL_OUT_BIT = DEF_CNT_W;
  typedef enum logic [2:0] {
    S_IDLE, S_CFG_IN, S_CFG_OUT, S_CFG_WAIT, S_SEND, S_RECV, S_DONE
  } npu_state_e;
endpackage

// File: rtl/npu_host_skid_buf.sv
// npu_host_skid_buf: 2-entry FIFO catching output FIFO read data one cycle after the read strobe
module npu_host_skid_buf
  import npu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [1:0]        o_occ
);
  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr;
  logic              r_rd;
  logic [1:0]        r_occ;
  assign o_data = r_mem[r_rd];
  assign o_valid = r_occ != 2'd0;
  assign o_occ = r_occ;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      if (i_push && !i_pop) r_occ <= r_occ + 2'd1;
      else if (i_pop && !i_push) r_occ <= r_occ - 2'd1;
    end
  end
endmodule

// File: rtl/npu_host_dispatcher.sv
// npu_host_dispatcher: host-side NPU job initiator; writes counts to the config FIFO,
// streams input words in and drains exactly out_cnt result words back to the host.
module npu_host_dispatcher
  import npu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [CNT_W-1:0]  host_req_in_cnt,
  input  logic [CNT_W-1:0]  host_req_out_cnt,
  input  logic              host_req_cfg,
  input  logic              host_in_valid,
  input  logic [DATA_W-1:0] host_in_data,
  output logic              host_in_ready,
  output logic              host_out_valid,
  output logic [DATA_W-1:0] host_out_data,
  input  logic              host_out_ready,
  output logic              cfg_fifo_wr_en,
  output logic [CNT_W+1:0]  cfg_fifo_wr_data,
  input  logic              cfg_fifo_full,
  input  logic              cfg_fifo_empty,
  output logic              in_fifo_wr_en,
  output logic [DATA_W-1:0] in_fifo_wr_data,
  input  logic              in_fifo_full,
  output logic              out_fifo_rd_en,
  input  logic [DATA_W-1:0] out_fifo_rd_data,
  input  logic              out_fifo_empty,
  output logic              busy,
  output logic              job_done,
  output logic [31:0]       job_cycles
);
  npu_state_e       r_state, w_next;
  logic [CNT_W-1:0] r_in_cnt, r_out_cnt, r_sent, r_issued, r_recv;
  logic             r_rd_pend;
  logic [31:0]      r_cyc, r_job_cycles, w_cyc_inc;
  logic             w_accept, w_in_wr, w_pop, w_rd, w_out_valid;
  logic             w_sent_last, w_recv_last;
  logic [1:0]       w_cfg_sel, w_occ;
  logic [DATA_W-1:0] w_out_data;
  assign host_req_ready = r_state == S_IDLE;
  assign busy = !host_req_ready;
  assign job_done = r_state == S_DONE;
  assign job_cycles = r_job_cycles;
  assign w_accept = host_req_ready && host_req_valid;
  assign w_cyc_inc = (&r_cyc) ? r_cyc : r_cyc + 32'd1;
  assign w_cfg_sel = {r_state == S_CFG_IN, r_state == S_CFG_OUT};
  assign cfg_fifo_wr_en = (|w_cfg_sel) && !cfg_fifo_full;
  assign cfg_fifo_wr_data = cfg_fifo_wr_en ? {w_cfg_sel, w_cfg_sel[1] ? r_in_cnt : r_out_cnt} : '0;
  assign host_in_ready = (r_state == S_SEND) && !in_fifo_full && (r_sent != r_in_cnt);
  assign w_in_wr = host_in_valid && host_in_ready;
  assign in_fifo_wr_en = w_in_wr;
  assign in_fifo_wr_data = w_in_wr ? host_in_data : '0;
  assign w_sent_last = (r_sent == r_in_cnt) || (w_in_wr && (r_sent + CNT_W'(1) == r_in_cnt));
  assign host_out_valid = w_out_valid;
  assign host_out_data = w_out_data;
  assign w_pop = w_out_valid && host_out_ready;
  assign w_recv_last = (r_recv == r_out_cnt) || (w_pop && (r_recv + CNT_W'(1) == r_out_cnt));
  // a word popped this cycle frees its slot, which keeps reads back-to-back at full rate
  assign w_rd = (r_state == S_RECV) && !out_fifo_empty && (r_issued != r_out_cnt)
             && (({1'b0, w_occ} + {2'b0, r_rd_pend}) < (3'd2 + {2'b0, w_pop}));
  assign out_fifo_rd_en = w_rd;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (host_req_valid) w_next = host_req_cfg ? S_CFG_IN : S_SEND;
      S_CFG_IN:   if (!cfg_fifo_full) w_next = S_CFG_OUT;
      S_CFG_OUT:  if (!cfg_fifo_full) w_next = S_CFG_WAIT;
      S_CFG_WAIT: if (cfg_fifo_empty) w_next = S_SEND;
      S_SEND:     if (w_sent_last) w_next = S_RECV;
      S_RECV:     if (w_recv_last) w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_in_cnt <= '0;
      r_out_cnt <= '0;
      r_sent <= '0;
      r_issued <= '0;
      r_recv <= '0;
      r_rd_pend <= 1'b0;
      r_cyc <= '0;
      r_job_cycles <= '0;
    end else begin
      r_state <= w_next;
      r_rd_pend <= w_rd;
      if (w_accept) begin
        r_in_cnt <= host_req_in_cnt;
        r_out_cnt <= host_req_out_cnt;
        r_sent <= '0;
        r_issued <= '0;
        r_recv <= '0;
        r_cyc <= '0;
      end else begin
        if (w_in_wr) r_sent <= r_sent + CNT_W'(1);
        if (w_rd) r_issued <= r_issued + CNT_W'(1);
        if (w_pop) r_recv <= r_recv + CNT_W'(1);
        if (busy) r_cyc <= w_cyc_inc;
      end
      if (job_done) r_job_cycles <= w_cyc_inc;
    end
  end
  npu_host_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_push (r_rd_pend),
    .i_data (out_fifo_rd_data),
    .i_pop  (w_pop),
    .o_data (w_out_data),
    .o_valid(w_out_valid),
    .o_occ  (w_occ)
  );
endmodule
